dbg_bridge: RTL

DBG_BRIDGE -- requirements
Module: dbg_bridge

---
 rtl/dbg_bridge.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/dbg_bridge.sv
// dbg_bridge: 8N1 serial command bridge acting as epRISC register bus initiator.
// Optional inter-byte timeout enabled by defining DBG_BRIDGE_TIMEOUT_EN.
module dbg_bridge #(
  parameter int CLK_DIV      = 27,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRX,
  output logic        oTX,
  output logic [7:0]  oAddr,
  inout  wire  [31:0] bData,
  output logic        oWrite,
  output logic        oEnable,
  output logic        oBusy
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_st_t;

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, BUSW, BUSR, RESP
  } st_t;

  logic [1:0]    rx_sync;
  logic          rx_s, rx_prev;
  rx_st_t        rx_st, rx_st_n;
  logic [DW-1:0] rx_div;
  logic [3:0]    rx_tcnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_tick, rx_fall;
  logic          rx_mid, rx_end;

  assign rx_s    = rx_sync[1];
  assign rx_tick = (rx_div == DIV_MAX);
  assign rx_fall = rx_prev & ~rx_s;
  assign rx_mid  = rx_tick && (rx_tcnt == 4'd7);
  assign rx_end  = rx_tick && (rx_tcnt == 4'd15);

  always_comb begin
    rx_st_n = rx_st;
    unique case (rx_st)
      RX_IDLE:  if (rx_fall) rx_st_n = RX_START;
      RX_START: if (rx_mid) rx_st_n = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_end && rx_bit == 3'd7) rx_st_n = RX_STOP;
      RX_STOP:  if (rx_end) rx_st_n = RX_IDLE;
      default:  rx_st_n = RX_IDLE;
    endcase
  end

  // rx_prev resets low so a line held low at release never looks like an edge
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rx_sync  <= '0;
      rx_prev  <= 1'b0;
      rx_st    <= RX_IDLE;
      rx_div   <= '0;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], iRX};
      rx_prev  <= rx_s;
      rx_st    <= rx_st_n;
      rx_valid <= 1'b0;
      if (rx_st == RX_IDLE) begin
        rx_div  <= '0;
        rx_tcnt <= '0;
        rx_bit  <= '0;
      end else begin
        rx_div <= rx_tick ? '0 : rx_div + DW'(1);
        if (rx_tick)
          rx_tcnt <= (rx_st == RX_START && rx_tcnt == 4'd7)
                   ? '0 : rx_tcnt + 4'd1;
        if (rx_st == RX_DATA && rx_end) begin
          rx_byte <= {rx_s, rx_byte[7:1]};
          rx_bit  <= rx_bit + 3'd1;
        end
        if (rx_st == RX_STOP && rx_end)
          rx_valid <= rx_s;
      end
    end
  end

  logic          tx_busy, tx_start, tx_tick;
  logic [DW-1:0] tx_div;
  logic [3:0]    tx_tcnt, tx_bit;
  logic [8:0]    tx_sh;
  logic [7:0]    tx_data;

  assign tx_tick = (tx_div == DIV_MAX);

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      tx_busy <= 1'b0;
      tx_div  <= '0;
      tx_tcnt <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
      oTX     <= 1'b1;
    end else if (!tx_busy) begin
      tx_div  <= '0;
      tx_tcnt <= '0;
      tx_bit  <= '0;
      if (tx_start) begin
        tx_busy <= 1'b1;
        tx_sh   <= {1'b1, tx_data};
        oTX     <= 1'b0;
      end
    end else begin
      tx_div <= tx_tick ? '0 : tx_div + DW'(1);
      if (tx_tick) begin
        tx_tcnt <= tx_tcnt + 4'd1;
        if (tx_tcnt == 4'd15) begin
          tx_bit <= tx_bit + 4'd1;
          if (tx_bit == 4'd9) begin
            tx_busy <= 1'b0;
          end else begin
            oTX   <= tx_sh[0];
            tx_sh <= {1'b1, tx_sh[8:1]};
          end
        end
      end
    end
  end

  st_t         st, st_n;
  logic        wr_flag;
  logic [1:0]  wcnt;
  logic [31:0] wdata;
  logic [31:0] resp_buf;
  logic [2:0]  resp_left;
  logic        gap_hit;

`ifdef DBG_BRIDGE_TIMEOUT_EN
  localparam int GAP_MAX = TIMEOUT_BITS * 16 * CLK_DIV;
  localparam int GW = $clog2(GAP_MAX + 1);
  logic [GW-1:0] gap;

  assign gap_hit = (gap == GW'(GAP_MAX));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)
      gap <= '0;
    else if (!(st == ADDR || st == WDATA) || rx_valid)
      gap <= '0;
    else if (!gap_hit)
      gap <= gap + GW'(1);
  end
`else
  assign gap_hit = 1'b0;
`endif

  assign tx_data = resp_buf[7:0];
  assign oBusy   = (st != IDLE);
  assign bData   = (st == BUSW) ? wdata : 'z;

  always_comb begin
    st_n     = st;
    tx_start = 1'b0;
    unique case (st)
      IDLE:
        if (rx_valid)
          st_n = (rx_byte == CMD_W || rx_byte == CMD_R)
               ? ADDR : RESP;
      ADDR:  if (rx_valid) st_n = wr_flag ? WDATA : BUSR;
      WDATA: if (rx_valid && wcnt == 2'd3) st_n = BUSW;
      BUSW:  st_n = RESP;
      BUSR:  st_n = RESP;
      RESP: begin
        tx_start = !tx_busy && (resp_left != 3'd0);
        if (!tx_busy && resp_left == 3'd0) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
    if (gap_hit && (st == ADDR || st == WDATA))
      st_n = IDLE;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      st        <= IDLE;
      wr_flag   <= 1'b0;
      oAddr     <= '0;
      wcnt      <= '0;
      wdata     <= '0;
      resp_buf  <= '0;
      resp_left <= '0;
      oEnable   <= 1'b0;
      oWrite    <= 1'b0;
    end else begin
      st      <= st_n;
      oEnable <= (st_n == BUSW) || (st_n == BUSR);
      oWrite  <= (st_n == BUSW);
      if (st == IDLE && rx_valid) begin
        wr_flag   <= (rx_byte == CMD_W);
        resp_buf  <= 32'h3F;
        resp_left <= 3'd1;
      end
      if (st == ADDR) begin
        wcnt <= '0;
        if (rx_valid) oAddr <= rx_byte;
      end
      if (st == WDATA && rx_valid) begin
        wdata <= {rx_byte, wdata[31:8]};
        wcnt  <= wcnt + 2'd1;
      end
      if (st == BUSW) begin
        resp_buf  <= 32'h4B;
        resp_left <= 3'd1;
      end
      if (st == BUSR) begin
        resp_buf  <= bData;
        resp_left <= 3'd4;
      end
      if (tx_start) begin
        resp_buf  <= {8'h00, resp_buf[31:8]};
        resp_left <= resp_left - 3'd1;
      end
    end
  end

endmodule
